dobbelsteen_axil_slave: RTL and testbench

AXI4-Lite slave peripheral implementing the electronic die ("dobbelsteen") on the MiniZED. It is the register target driven by the AXI VIP master in the block-design bench and by the PS in hardware. Software seeds a 16-bit LFSR, sets a roll length and tick divider, then starts a roll. The block animates faces on a 7-LED pip output and latches the final face into a readable result register with done status and interrupt.

---
 rtl/dobbelsteen_pkg.sv | 48 ++++
 rtl/dobbelsteen_lfsr16.sv | 27 ++
 rtl/dobbelsteen_axil_slave.sv | 174 +++++++++++++++++
 tb/tb_dobbelsteen_axil_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dobbelsteen_pkg.sv
// Shared constants, types and helpers for the dobbelsteen electronic die peripheral.
package dobbelsteen_pkg;

  // Word indices (byte address >> 2) of the register map.
  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_SEED       = 3'd1;
  localparam logic [2:0] REG_DIVIDER    = 3'd2;
  localparam logic [2:0] REG_SCRATCH    = 3'd3;
  localparam logic [2:0] REG_STATUS     = 3'd4;
  localparam logic [2:0] REG_RESULT     = 3'd5;
  localparam logic [2:0] REG_ROLL_COUNT = 3'd6;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic {StIdle, StRolling} state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
  endfunction

  function automatic logic [2:0] face_of(input logic [15:0] v);
    return 3'(v[15:8] % 8'd6) + 3'd1;
  endfunction

  // Pip order bit0..6 = TL, TR, ML, C, MR, BL, BR.
  function automatic logic [6:0] face_to_pips(input logic [2:0] face);
    case (face)
      3'd1:    return 7'h08;
      3'd2:    return 7'h41;
      3'd3:    return 7'h49;
      3'd4:    return 7'h63;
      3'd5:    return 7'h6B;
      3'd6:    return 7'h77;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dobbelsteen_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load; a zero seed maps to the default.
module dobbelsteen_lfsr16
  import dobbelsteen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_DEFAULT;
    end else if (load_i) begin
      lfsr_q <= (load_value_i == 16'h0000) ? LFSR_DEFAULT : load_value_i;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/dobbelsteen_axil_slave.sv
// AXI4-Lite register target for the electronic die: register file, roll FSM, pips and irq.
module dobbelsteen_axil_slave
  import dobbelsteen_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [6:0]                      dice_pips,
  output logic                            irq
);

  state_e      state_q;
  logic [31:0] ctrl_q, seed_q, divider_q, scratch_q, roll_count_q, div_cnt_q, rdata_q;
  logic [7:0]  tick_cnt_q;
  logic [2:0]  result_q;
  logic [6:0]  pips_q;
  logic        done_q, irq_q, wready_q, bvalid_q, arready_q, rvalid_q;

  logic        wr_hs, rd_hs, start, seed_load, tick;
  logic [2:0]  wr_idx, rd_idx, face;
  logic [31:0] ctrl_wr, seed_wr, rd_mux;
  logic [7:0]  roll_ticks;
  logic [15:0] lfsr_value;
  logic        unused_bits;

  assign wr_hs   = wready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs   = arready_q & S_AXI_ARVALID;
  assign wr_idx  = S_AXI_AWADDR[4:2];
  assign rd_idx  = S_AXI_ARADDR[4:2];
  assign ctrl_wr = apply_wstrb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
  assign seed_wr = apply_wstrb(seed_q, S_AXI_WDATA, S_AXI_WSTRB);

  assign start      = wr_hs && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0] &&
                      (state_q == StIdle);
  assign seed_load  = wr_hs && (wr_idx == REG_SEED) && (state_q == StIdle);
  assign tick       = (state_q == StRolling) && (div_cnt_q == divider_q);
  assign roll_ticks = (ctrl_wr[15:8] == 8'd0) ? 8'd1 : ctrl_wr[15:8];
  // Face comes from the value the LFSR is about to step to on this tick.
  assign face       = face_of(lfsr_next(lfsr_value));

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  dobbelsteen_lfsr16 u_lfsr (
    .clk_i        (S_AXI_ACLK),
    .rst_ni       (S_AXI_ARESETN),
    .load_i       (seed_load),
    .load_value_i (seed_wr[15:0]),
    .step_i       (tick),
    .value_o      (lfsr_value)
  );

  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      REG_CTRL:       rd_mux = ctrl_q;
      REG_SEED:       rd_mux = seed_q;
      REG_DIVIDER:    rd_mux = divider_q;
      REG_SCRATCH:    rd_mux = scratch_q;
      REG_STATUS:     rd_mux = {30'h0, done_q, state_q == StRolling};
      REG_RESULT:     rd_mux = {29'h0, result_q};
      REG_ROLL_COUNT: rd_mux = roll_count_q;
      default:        rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      ctrl_q    <= 32'h0;
      seed_q    <= 32'h0;
      divider_q <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      wready_q  <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~wready_q;
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        case (wr_idx)
          REG_CTRL:    ctrl_q    <= ctrl_wr;
          REG_SEED:    seed_q    <= seed_wr;
          REG_DIVIDER: divider_q <= apply_wstrb(divider_q, S_AXI_WDATA, S_AXI_WSTRB);
          REG_SCRATCH: scratch_q <= apply_wstrb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= StIdle;
      div_cnt_q    <= 32'h0;
      tick_cnt_q   <= 8'h0;
      result_q     <= 3'h0;
      done_q       <= 1'b0;
      roll_count_q <= 32'h0;
      pips_q       <= 7'h0;
      irq_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRolling;
            done_q     <= 1'b0;
            div_cnt_q  <= 32'h0;
            tick_cnt_q <= roll_ticks;
          end
        end
        StRolling: begin
          if (tick) begin
            div_cnt_q <= 32'h0;
            pips_q    <= face_to_pips(face);
            if (tick_cnt_q == 8'd1) begin
              result_q     <= face;
              done_q       <= 1'b1;
              roll_count_q <= roll_count_q + 32'd1;
              state_q      <= StIdle;
            end else begin
              tick_cnt_q <= tick_cnt_q - 8'd1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 32'd1;
          end
        end
      endcase
      irq_q <= done_q & ctrl_q[1];
    end
  end

  assign S_AXI_AWREADY = wready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign dice_pips     = pips_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_dobbelsteen_axil_slave.sv
// Directed self-checking bench for dobbelsteen_axil_slave with hand-computed die outcomes.
module tb_dobbelsteen_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [6:0]  pips;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int lat;
  int h_roll;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dobbelsteen_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .dice_pips     (pips),
    .irq           (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    check_eq("wr_awready", 32'(awready), 32'd1);
    check_eq("wr_wready", 32'(wready), 32'd1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_awready_pulse", 32'(awready), 32'd0);
    check_eq("wr_bvalid", 32'(bvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("wr_bvalid_hold", 32'(bvalid), 32'd1);
    end
    check_eq("wr_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_eq("wr_bvalid_clear", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input string tag, input logic [4:0] addr, input logic [31:0] exp,
                          input int hold);
    int n = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    if (!arready) check_eq({tag, "_arready"}, 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check_eq(tag, rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
      check_eq({tag, "_hold_rdata"}, rdata, exp);
    end
    check_eq({tag, "_rresp"}, 32'(rresp), 32'd0);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic wait_irq(input int max, output int l);
    int n = 0;
    while (!irq && n < max) begin @(posedge clk); #1; n++; end
    if (!irq) check_eq("irq_timeout", 32'(irq), 32'd1);
    l = cyc - hs_cyc;
  endtask

  task automatic wait_pips(input logic [6:0] val, input int max, output int l);
    int n = 0;
    while (pips !== val && n < max) begin @(posedge clk); #1; n++; end
    if (pips !== val) check_eq("pips_timeout", 32'(pips), 32'(val));
    l = cyc - hs_cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] vip_vals [4];
    vip_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    #1;
    check_eq("rst_pips", 32'(pips), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    axi_read("rst_result", 5'h14, 32'd0, 0);
    axi_read("rst_status", 5'h10, 32'd0, 0);

    // VIP-style write/readback; CTRL=1 launches a 1-tick roll from 0xACE1 -> 0xE270 -> face 5.
    for (int i = 0; i < 4; i++) axi_write(5'(4 * i), vip_vals[i], 4'hF, 0);
    for (int i = 0; i < 4; i++) axi_read("vip_readback", 5'(4 * i), vip_vals[i], 0);
    axi_read("vip_status", 5'h10, 32'd2, 0);
    axi_read("vip_result", 5'h14, 32'd5, 0);
    axi_read("vip_count", 5'h18, 32'd1, 0);

    // Seed 1, 3 ticks: 0xB400 f1, 0x5A00 f1, 0x2D00 f4.
    axi_write(5'h04, 32'h1, 4'hF, 0);
    axi_write(5'h08, 32'h0, 4'hF, 0);
    axi_write(5'h00, 32'h0301, 4'hF, 0);
    wait_pips(7'h63, 30, lat);
    check_eq("roll3_latency", 32'(lat), 32'd4);
    axi_read("roll3_status", 5'h10, 32'd2, 0);
    axi_read("roll3_result", 5'h14, 32'd4, 0);
    axi_read("roll3_count", 5'h18, 32'd2, 0);
    check_eq("roll3_pips", 32'(pips), 32'h63);

    // Seed 1, 1 tick with IRQ_EN: face 1, irq one cycle after DONE.
    axi_write(5'h04, 32'h1, 4'hF, 0);
    axi_write(5'h00, 32'h0103, 4'hF, 0);
    wait_irq(30, lat);
    check_eq("irq_latency", 32'(lat), 32'd3);
    check_eq("roll1_pips", 32'(pips), 32'h08);
    axi_read("roll1_result", 5'h14, 32'd1, 0);

    // DIVIDER=9, 4 ticks from seed 1: faces 1,1,4,5; mid-roll start and seed are ignored.
    axi_write(5'h04, 32'h1, 4'hF, 0);
    axi_write(5'h08, 32'd9, 4'hF, 0);
    axi_write(5'h00, 32'h0400, 4'hF, 0);
    axi_write(5'h00, 32'h0403, 4'hF, 0);
    h_roll = hs_cyc;
    axi_read("div_status_busy", 5'h10, 32'd1, 0);
    axi_write(5'h00, 32'h0403, 4'hF, 0);
    axi_write(5'h04, 32'h1234, 4'hF, 0);
    hs_cyc = h_roll;
    wait_irq(100, lat);
    check_eq("div_busy_cycles", 32'(lat - 2), 32'd40);
    axi_read("div_result", 5'h14, 32'd5, 0);
    axi_read("div_count", 5'h18, 32'd4, 0);
    axi_read("div_status", 5'h10, 32'd2, 0);
    axi_read("div_seed", 5'h04, 32'h1234, 0);
    check_eq("div_pips", 32'(pips), 32'h6B);

    // Byte strobes, dropped writes, unmapped read, stalled responses.
    axi_write(5'h0C, 32'h0, 4'hF, 0);
    axi_write(5'h0C, 32'hAABBCCDD, 4'h2, 5);
    axi_read("scratch_strb", 5'h0C, 32'h0000CC00, 5);
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, 0);
    axi_read("ro_result", 5'h14, 32'd5, 0);
    axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0);
    axi_read("unmapped", 5'h1C, 32'd0, 0);
    axi_read("ctrl_kept", 5'h00, 32'h0403, 0);

    // Reset mid-roll: LFSR 0x1680 -> 0x0B40 gives face 6 on the first tick.
    axi_write(5'h00, 32'h0403, 4'hF, 0);
    repeat (15) @(posedge clk);
    #1;
    check_eq("pre_reset_pips", 32'(pips), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_pips", 32'(pips), 32'd0);
    check_eq("reset_irq", 32'(irq), 32'd0);
    check_eq("reset_bvalid", 32'(bvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    axi_read("post_rst_status", 5'h10, 32'd0, 0);
    axi_read("post_rst_result", 5'h14, 32'd0, 0);
    axi_read("post_rst_count", 5'h18, 32'd0, 0);
    axi_read("post_rst_ctrl", 5'h00, 32'd0, 0);
    axi_read("post_rst_div", 5'h08, 32'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
